// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: jump FSM states and board constants.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AIR      = 2'd1,
    COOLDOWN = 2'd2
  } jumpStateT;

  localparam int CLK_HZ  = 27_000_000;
  localparam int FRAME_W = 8;
  localparam int FCNT_W  = 8;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, level debouncer and press pulse for an active-low button.
// A press is only reported once the button has been seen released after reset,
// so a button held through reset cannot start anything by itself.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnN,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       syncReg;
  logic [1:0]       validReg;
  logic             levelReg;
  logic [CNT_W-1:0] cntReg;
  logic             armedReg;
  logic             pressReg;

  // Synchronise, debounce and emit a one-cycle pulse on an accepted 1->0 change.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncReg  <= 2'b11;
      validReg <= 2'b00;
      levelReg <= 1'b1;
      cntReg   <= '0;
      armedReg <= 1'b0;
      pressReg <= 1'b0;
    end else begin
      syncReg  <= {syncReg[0], btnN};
      validReg <= {validReg[0], 1'b1};
      pressReg <= 1'b0;
      if (syncReg[1] == levelReg) begin
        cntReg <= '0;
      end else if (cntReg == LAST) begin
        levelReg <= syncReg[1];
        cntReg   <= '0;
        pressReg <= armedReg && !syncReg[1];
      end else begin
        cntReg <= cntReg + 1'b1;
      end
      // validReg[1] marks that the synchroniser now reflects the real pin.
      if (validReg[1] && syncReg[1] && levelReg) begin
        armedReg <= 1'b1;
      end
    end
  end

  assign press = pressReg;

endmodule

// File: rtl/jump_controller.sv
// Converts the debounced jump button into the cat's airborne flag, with
// airtime and cooldown counted in display frames.
module jump_controller
  import dino_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int AIR_FRAMES      = 30,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_n,
  input  logic [FRAME_W-1:0] frameNumber,
  output logic               jumpOffset,
  output logic               jumpStart,
  output logic               busy
);

  logic press;
  logic tick;

  jumpStateT          stateReg, stateNext;
  logic [FCNT_W-1:0]  airCntReg, airCntNext;
  logic [FCNT_W-1:0]  cdCntReg, cdCntNext;
  logic               pendingReg, pendingNext;
  logic               jumpOffsetReg, jumpOffsetNext;
  logic               jumpStartReg, jumpStartNext;
  logic               busyReg, busyNext;
  logic [FRAME_W-1:0] prevFrameReg;
  logic               primedReg;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebouncer (
    .clk  (clk),
    .reset(reset),
    .btnN (btn_n),
    .press(press)
  );

  // Remember last frame number; the first cycle after reset only primes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prevFrameReg <= '0;
      primedReg    <= 1'b0;
    end else begin
      prevFrameReg <= frameNumber;
      primedReg    <= 1'b1;
    end
  end

  assign tick = primedReg && (frameNumber != prevFrameReg);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= IDLE;
      airCntReg     <= '0;
      cdCntReg      <= '0;
      pendingReg    <= 1'b0;
      jumpOffsetReg <= 1'b0;
      jumpStartReg  <= 1'b0;
      busyReg       <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      airCntReg     <= airCntNext;
      cdCntReg      <= cdCntNext;
      pendingReg    <= pendingNext;
      jumpOffsetReg <= jumpOffsetNext;
      jumpStartReg  <= jumpStartNext;
      busyReg       <= busyNext;
    end
  end

  // Next-state logic; a press in IDLE takes priority over a coincident tick.
  always_comb begin
    stateNext      = stateReg;
    airCntNext     = airCntReg;
    cdCntNext      = cdCntReg;
    pendingNext    = pendingReg;
    jumpOffsetNext = jumpOffsetReg;
    jumpStartNext  = 1'b0;
    busyNext       = busyReg;
    case (stateReg)
      IDLE: begin
        if (press || pendingReg) begin
          stateNext      = AIR;
          airCntNext     = FCNT_W'(AIR_FRAMES);
          jumpOffsetNext = 1'b1;
          jumpStartNext  = 1'b1;
          pendingNext    = 1'b0;
          busyNext       = 1'b1;
        end
      end
      AIR: begin
        if (tick) begin
          airCntNext = airCntReg - 1'b1;
          if (airCntReg == FCNT_W'(1)) begin
            jumpOffsetNext = 1'b0;
            if (COOLDOWN_FRAMES == 0) begin
              stateNext = IDLE;
              busyNext  = 1'b0;
            end else begin
              stateNext = COOLDOWN;
              cdCntNext = FCNT_W'(COOLDOWN_FRAMES);
            end
          end
        end
      end
      COOLDOWN: begin
        if (press) begin
          pendingNext = 1'b1;
        end
        if (tick) begin
          cdCntNext = cdCntReg - 1'b1;
          if (cdCntReg == FCNT_W'(1)) begin
            stateNext = IDLE;
            busyNext  = 1'b0;
          end
        end
      end
      default: begin
        stateNext      = IDLE;
        jumpOffsetNext = 1'b0;
        busyNext       = 1'b0;
      end
    endcase
  end

  assign jumpOffset = jumpOffsetReg;
  assign jumpStart  = jumpStartReg;
  assign busy       = busyReg;

endmodule
